inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter AW, default 8, SHALL set the PC and memory address width, matching the pc_reg output.
REQ-002 Parameter DW, default 32, SHALL set the instruction width.
REQ-003 Parameter DEPTH, default 2, SHALL set the number of entries in the fetched-instruction FIFO.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-006 pc_in  in  AW  SHALL carry the current PC from pc_reg.
REQ-007 pc_advance  out  1  SHALL tell pc_reg to advance; high exactly in cycles where a memory request is accepted.
REQ-008 mem_req  out  1  SHALL be the instruction-memory read request.
REQ-009 mem_addr  out  AW  SHALL be the read address, equal to pc_in while mem_req is high.
REQ-010 mem_gnt  in  1  SHALL indicate that memory accepts the request this cycle.
REQ-011 mem_rvalid  in  1  SHALL indicate that mem_rdata is valid.
REQ-012 mem_rdata  in  DW  SHALL be the returned instruction word.
REQ-013 flush  in  1  SHALL discard all fetched and in-flight instructions (branch redirect).
REQ-014 id_valid  out  1  SHALL indicate that id_inst and id_pc are valid for decode.
REQ-015 id_ready  in  1  SHALL indicate that decode accepts the head entry.
REQ-016 id_inst  out  DW  SHALL be the head FIFO instruction.
REQ-017 id_pc  out  AW  SHALL be the PC of the head FIFO instruction.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT and DROP; at most one memory request SHALL be outstanding.
REQ-019 In IDLE with !flush and count<DEPTH, the FSM SHALL move to REQ on the next edge; otherwise it SHALL stay in IDLE.
REQ-020 mem_req SHALL equal (state==REQ) && !flush; mem_addr SHALL be pc_in.
REQ-021 In REQ, when mem_req && mem_gnt: pc_advance=1, pc_in SHALL be latched into req_pc, and the next state SHALL be WAIT; otherwise the FSM SHALL hold REQ with mem_addr tracking pc_in.
REQ-022 In WAIT with mem_rvalid && !flush: {req_pc, mem_rdata} SHALL be pushed; next state SHALL be REQ if post-update count<DEPTH, else IDLE.
REQ-023 Flush in REQ or IDLE: next state SHALL be IDLE and no grant SHALL be taken (pc_advance=0).
REQ-024 Flush in WAIT without mem_rvalid: next state SHALL be DROP; with mem_rvalid the same cycle, data SHALL be discarded and next state SHALL be IDLE.
REQ-025 DROP SHALL discard the next mem_rvalid and then go to IDLE; flush while in DROP SHALL keep DROP until that rvalid arrives.
REQ-026 Flush SHALL clear the FIFO (count=0, pointers=0) on the same edge and SHALL override any push or pop that cycle.
REQ-027 FIFO: id_valid = (count!=0); pop on id_valid && id_ready; push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-028 A request SHALL issue only when count<DEPTH, so a push SHALL never occur while full; pop while empty SHALL be ignored.
REQ-029 Latency: an instruction SHALL appear on id_valid on the edge following its mem_rvalid.

Reset
REQ-030 While rst_n=0: state=IDLE, count=0, pointers=0, req_pc=0, id_inst=0, id_pc=0, id_valid=0, mem_req=0, pc_advance=0, taking effect immediately without a clock edge.
REQ-031 Assertion of rst_n mid-request SHALL abandon the request; after release, any stale mem_rvalid SHALL NOT be pushed unless the FSM is in WAIT.

Verification
REQ-032 Reset release; pc_in=0x00, gnt=1, rvalid one cycle after grant with rdata=0x00000013, id_ready=1 -> id_valid rises with id_pc=0x00, id_inst=0x00000013; pc_advance is one-cycle pulses.
REQ-033 id_ready=0; fetch PCs 0x04 and 0x08 -> count=2, FSM parks in IDLE, mem_req=0; id_ready=1 -> entries pop in order 0x04 then 0x08, and fetching resumes.
REQ-034 gnt held 0 for 3 cycles while pc_in changes 0x10->0x14 -> mem_addr follows pc_in, pc_advance=0, and the request for 0x14 is accepted when gnt=1.
REQ-035 flush in WAIT, rvalid two cycles later with rdata=0xDEADBEEF -> FSM passes through DROP, the data is never visible, id_valid=0, then normal fetching resumes.
REQ-036 flush with FIFO full and the same cycle as id_ready=1 -> count=0 on the next edge, id_valid=0, no pop is counted.
REQ-037 rst_n pulsed low between clock edges during WAIT -> outputs are zero immediately and the FSM is in IDLE after release.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one instruction-memory read at a time at the
// PC supplied by pc_reg, and buffers returned words with their PCs in a small
// FIFO for decode. A flush drops buffered entries, and a response still in
// flight is discarded when it returns.
module inst_fetch #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] pc_in,
   output logic          pc_advance,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   input  logic          flush,
   output logic          id_valid,
   input  logic          id_ready,
   output logic [DW-1:0] id_inst,
   output logic [AW-1:0] id_pc
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   req_pc_q, req_pc_d;
   logic [CntW-1:0] count_q, count_d;
   logic [CntW-1:0] count_upd;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [DW-1:0]   inst_q [DEPTH];
   logic [AW-1:0]   pc_q   [DEPTH];
   logic            push;
   logic            pop;

   // FIFO events; flush masks both so it wins over any push or pop
   always_comb begin
      push = (state_q == StWait) && mem_rvalid && !flush;
      pop  = (count_q != '0) && id_ready && !flush;
   end

   // Occupancy after this cycle's push/pop, ignoring flush
   always_comb begin
      count_upd = count_q;
      if (push && !pop) begin
         count_upd = count_q + 1'b1;
      end else if (!push && pop) begin
         count_upd = count_q - 1'b1;
      end
   end

   // FIFO pointer and count next-state, with flush clearing everything
   always_comb begin
      count_d  = count_upd;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // FIFO control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q <= '{default: '0};
         pc_q   <= '{default: '0};
      end else if (push) begin
         inst_q[wr_ptr_q] <= mem_rdata;
         pc_q[wr_ptr_q]   <= req_pc_q;
      end
   end

   // Decode-side view of the FIFO head
   always_comb begin
      id_valid = (count_q != '0);
      id_inst  = inst_q[rd_ptr_q];
      id_pc    = pc_q[rd_ptr_q];
   end

   // FSM state register plus the PC of the outstanding request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
      end
   end

   // FSM next-state: a single outstanding request, drained via StDrop on flush
   always_comb begin
      state_d  = state_q;
      req_pc_d = req_pc_q;
      case (state_q)
         StIdle: begin
            if (!flush && (count_q < CntFull)) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (flush) begin
               state_d = StIdle;
            end else if (mem_gnt) begin
               state_d  = StWait;
               req_pc_d = pc_in;
            end
         end
         StWait: begin
            if (flush) begin
               // Response arriving with the flush is simply dropped
               state_d = mem_rvalid ? StIdle : StDrop;
            end else if (mem_rvalid) begin
               state_d = (count_upd < CntFull) ? StReq : StIdle;
            end
         end
         StDrop: begin
            if (mem_rvalid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs towards memory and pc_reg
   always_comb begin
      mem_req    = (state_q == StReq) && !flush;
      mem_addr   = pc_in;
      pc_advance = mem_req && mem_gnt;
   end

   // Requests only issue with space free, so a push can never hit a full FIFO
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (count_q < CntFull));

endmodule
